// File: rtl/stack_drain_packer.sv
// rtl/stack_drain_packer.sv - drains a LIFO stack and packs popped entries into wide words
module stack_drain_packer #(
    parameter int DATA_WIDTH = 3,
    parameter int PACK_COUNT = 5,
    parameter int CNT_W      = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             stack_empty,
    input  logic                             stack_full,
    input  logic                             stack_threshold,
    input  logic                             stack_error,
    input  logic [DATA_WIDTH-1:0]            stack_data,
    input  logic                             flush,
    output logic                             pop,
    output logic [DATA_WIDTH*PACK_COUNT-1:0] out_data,
    output logic [CNT_W-1:0]                 out_count,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        OUT   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] PACK_MAX = CNT_W'(PACK_COUNT);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] captured;
    logic             in_flight;
    logic             flush_pend;
    logic             start_drain;
    logic             handshake;

    assign out_count = captured;
    assign handshake = out_valid & out_ready;

    // Next-state and strobe decode; pop is gated by empty so a drained stack is never popped.
    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        out_valid   = 1'b0;
        start_drain = 1'b0;
        case (state)
            IDLE: begin
                if ((stack_threshold | stack_full | flush_pend | flush) & !stack_empty) begin
                    start_drain = 1'b1;
                    state_nxt   = DRAIN;
                end
            end
            DRAIN: begin
                pop = !stack_empty && (issued < PACK_MAX);
                if (!in_flight &&
                    ((captured == PACK_MAX) ||
                     (stack_empty && (issued == captured) && (captured != '0)))) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register plus issue/capture counters; counters clear once the word is taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            issued    <= '0;
            captured  <= '0;
            in_flight <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_flight <= pop;
            if (handshake) begin
                issued   <= '0;
                captured <= '0;
            end else begin
                if (pop) begin
                    issued <= issued + 1'b1;
                end
                if (in_flight) begin
                    captured <= captured + 1'b1;
                end
            end
        end
    end

    // Entry returned for last cycle's pop lands in the next free slot; slot 0 is the stack top.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data <= '0;
        end else if (handshake) begin
            out_data <= '0;
        end else if (in_flight) begin
            for (int i = 0; i < PACK_COUNT; i++) begin
                if (captured == CNT_W'(i)) begin
                    out_data[i*DATA_WIDTH +: DATA_WIDTH] <= stack_data;
                end
            end
        end
    end

    // Flush requests are remembered until a drain starts, including ones seen while busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_pend <= 1'b0;
        end else if (start_drain) begin
            flush_pend <= 1'b0;
        end else if (flush) begin
            flush_pend <= 1'b1;
        end
    end

    // Sticky error: stack reports an error, or shows empty while a popped entry is returned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (stack_error || (in_flight && stack_empty)) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stack_drain_packer.sv
// tb/tb_stack_drain_packer.sv - randomized self-checking bench for stack_drain_packer
module tb_stack_drain_packer;

    localparam int DW     = 3;
    localparam int PC     = 5;
    localparam int CW     = 3;
    localparam int WW     = DW * PC;
    localparam int THRESH = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          stack_empty;
    logic          stack_full;
    logic          stack_threshold;
    logic          stack_error = 1'b0;
    logic [DW-1:0] stack_data = '0;
    logic          flush = 1'b0;
    logic          pop;
    logic [WW-1:0] out_data;
    logic [CW-1:0] out_count;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          err;

    int            stk_n = 0;
    logic [DW-1:0] stk_mem [0:7];
    logic [DW-1:0] load_vals [0:4];
    int            load_n = 0;
    int            load_seq = 0;
    int            load_done = 0;

    int               n_cmp = 0;
    int               n_bad = 0;
    logic [WW+CW-1:0] got_q [$];
    int               rd_idx = 0;
    int               pop_cnt = 0;
    int               run = 0;
    int               last_run = 0;
    logic             hold_prev = 1'b0;
    logic [WW-1:0]    prev_data = '0;
    logic [CW-1:0]    prev_count = '0;
    logic             m_err = 1'b0;
    logic             pop_prev = 1'b0;
    logic [DW-1:0]    ref_stk [$];
    logic             rnd_ready = 1'b0;

    always #5 clk = ~clk;

    assign stack_empty     = (stk_n == 0);
    assign stack_full      = (stk_n == PC);
    assign stack_threshold = (stk_n >= THRESH);

    stack_drain_packer #(
        .DATA_WIDTH (DW),
        .PACK_COUNT (PC),
        .CNT_W      (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stack_empty     (stack_empty),
        .stack_full      (stack_full),
        .stack_threshold (stack_threshold),
        .stack_error     (stack_error),
        .stack_data      (stack_data),
        .flush           (flush),
        .pop             (pop),
        .out_data        (out_data),
        .out_count       (out_count),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .err             (err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // LIFO stack model: pop registered on the edge, data_out valid the following cycle.
    always @(posedge clk) begin
        if (pop && stk_n > 0) begin
            stack_data <= stk_mem[stk_n-1];
            stk_n      <= stk_n - 1;
        end else if (load_seq != load_done) begin
            for (int i = 0; i < load_n; i++) stk_mem[stk_n+i] <= load_vals[i];
            stk_n     <= stk_n + load_n;
            load_done <= load_seq;
        end
    end

    // Observer: collects accepted words and checks protocol rules every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            hold_prev = 1'b0;
            m_err     = 1'b0;
            pop_prev  = 1'b0;
            run       = 0;
        end else begin
            check("err", 64'(err), 64'(m_err));
            m_err    = m_err | stack_error | (pop_prev & stack_empty);
            pop_prev = pop;
            if (pop) begin
                check("pop_nonempty", 64'(stack_empty), 64'd0);
                pop_cnt++;
                run++;
            end else begin
                if (run > 0) last_run = run;
                run = 0;
            end
            if (out_valid) check("pop_in_out", 64'(pop), 64'd0);
            if (hold_prev) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'(out_data), 64'(prev_data));
                check("hold_count", 64'(out_count), 64'(prev_count));
            end
            hold_prev  = out_valid & !out_ready;
            prev_data  = out_data;
            prev_count = out_count;
            if (out_valid && out_ready) got_q.push_back({out_count, out_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_list(input int n);
        load_n = n;
        load_seq++;
        for (int i = 0; i < n; i++) ref_stk.push_back(load_vals[i]);
        tick();
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    function automatic logic [WW-1:0] pack_exp();
        logic [WW-1:0] w;
        int n;
        w = '0;
        n = ref_stk.size();
        for (int i = 0; i < n; i++) w[i*DW +: DW] = ref_stk[n-1-i];
        return w;
    endfunction

    task automatic expect_word(input string tag, input logic [WW-1:0] ew, input int ec, input int budget);
        int k;
        logic [WW+CW-1:0] g;
        k = 0;
        while (got_q.size() <= rd_idx && k < budget) begin
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            tick();
            k++;
        end
        if (got_q.size() <= rd_idx) begin
            check({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            g = got_q[rd_idx];
            rd_idx++;
            check({tag, "_data"}, 64'(g[WW-1:0]), 64'(ew));
            check({tag, "_count"}, 64'(g[WW+CW-1:WW]), 64'(ec));
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k;
        k = 0;
        while (!out_valid && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_valid_seen"}, 64'(out_valid), 64'd1);
    endtask

    task automatic wait_pops(input string tag, input int base, input int n);
        int k;
        k = 0;
        while (pop_cnt - base < n && k < 30) begin
            tick();
            k++;
        end
        check({tag, "_pops_seen"}, 64'(pop_cnt - base >= n), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [WW-1:0] ew;
        int            base;

        // reset state
        tick();
        tick();
        check("rst_pop", 64'(pop), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_count", 64'(out_count), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        rst = 1'b1;
        tick();

        // full drain, pushed 1..5 with 5 on top
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) load_vals[i] = DW'(i + 1);
        base = pop_cnt;
        load_list(5);
        expect_word("full", 15'h14E5, 5, 60);
        ref_stk.delete();
        check("full_pops", 64'(pop_cnt - base), 64'd5);
        check("full_run", 64'(last_run), 64'd5);
        repeat (3) tick();
        check("full_single", 64'(got_q.size()), 64'(rd_idx));
        check("full_empty", 64'(stack_empty), 64'd1);

        // flush of a partial stack: 6 then 2
        load_vals[0] = 3'd6;
        load_vals[1] = 3'd2;
        base = pop_cnt;
        load_list(2);
        repeat (5) tick();
        check("part_no_pop", 64'(pop_cnt - base), 64'd0);
        pulse_flush();
        expect_word("part", 15'h0032, 2, 60);
        ref_stk.delete();
        check("part_pops", 64'(pop_cnt - base), 64'd2);

        // backpressure: hold the word 10 cycles
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) load_vals[i] = DW'($urandom);
        load_list(5);
        wait_valid("bp", 40);
        base = pop_cnt;
        repeat (10) tick();
        check("bp_no_pop", 64'(pop_cnt - base), 64'd0);
        check("bp_valid", 64'(out_valid), 64'd1);
        check("bp_no_hs", 64'(got_q.size()), 64'(rd_idx));
        out_ready = 1'b1;
        ew = pack_exp();
        ref_stk.delete();
        expect_word("bp", ew, 5, 2);

        // flush arriving while a word is waiting in OUT
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) load_vals[i] = DW'($urandom);
        load_list(3);
        wait_valid("fo", 40);
        ew = pack_exp();
        ref_stk.delete();
        load_vals[0] = DW'($urandom);
        load_list(1);
        pulse_flush();
        repeat (3) tick();
        check("fo_held", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        expect_word("fo_first", ew, 3, 5);
        ew = pack_exp();
        ref_stk.delete();
        expect_word("fo_second", ew, 1, 40);

        // asynchronous reset mid-drain after two captures
        for (int i = 0; i < 5; i++) load_vals[i] = DW'($urandom);
        base = pop_cnt;
        load_list(5);
        wait_pops("rmid", base, 3);
        rst = 1'b0;
        #1;
        check("rmid_pop", 64'(pop), 64'd0);
        check("rmid_valid", 64'(out_valid), 64'd0);
        check("rmid_data", 64'(out_data), 64'd0);
        check("rmid_count", 64'(out_count), 64'd0);
        check("rmid_err", 64'(err), 64'd0);
        repeat (3) void'(ref_stk.pop_back());
        tick();
        tick();
        rst = 1'b1;
        base = pop_cnt;
        repeat (10) tick();
        check("rmid_quiet_pop", 64'(pop_cnt - base), 64'd0);
        check("rmid_quiet_word", 64'(got_q.size()), 64'(rd_idx));
        pulse_flush();
        ew = pack_exp();
        ref_stk.delete();
        expect_word("rmid_rest", ew, 2, 40);

        // stack_error pulse mid-drain
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) load_vals[i] = DW'($urandom);
        base = pop_cnt;
        load_list(5);
        wait_pops("serr", base, 2);
        check("serr_before", 64'(err), 64'd0);
        stack_error = 1'b1;
        tick();
        stack_error = 1'b0;
        tick();
        check("serr_set", 64'(err), 64'd1);
        ew = pack_exp();
        ref_stk.delete();
        expect_word("serr", ew, 5, 40);
        check("serr_sticky", 64'(err), 64'd1);

        // randomized transactions with random backpressure
        for (int it = 0; it < 40; it++) begin
            int n;
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) load_vals[i] = DW'($urandom);
            base = pop_cnt;
            rnd_ready = 1'b1;
            load_list(n);
            if (n < THRESH) begin
                repeat ($urandom_range(0, 4)) tick();
                check("rnd_no_early", 64'(got_q.size()), 64'(rd_idx));
                pulse_flush();
            end else if ($urandom_range(0, 1) == 1) begin
                pulse_flush();
            end
            ew = pack_exp();
            ref_stk.delete();
            expect_word("rnd", ew, n, 300);
            rnd_ready = 1'b0;
            out_ready = 1'b1;
            repeat (3) tick();
            check("rnd_pops", 64'(pop_cnt - base), 64'(n));
            check("rnd_no_extra", 64'(got_q.size()), 64'(rd_idx));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
